layer_compositor: RTL and testbench
===================================

Name: layer_compositor

Overview:
Parametrised next-generation pixel compositor for the VGA path. It accepts per-pixel sprite (blob) requests tagged with a layer and a sprite-RAM address. It reads the requested layers from an internal 1-cycle-latency sprite RAM, top layer first, and stops at the first opaque pixel. One pixel is emitted per pixel strobe with a valid pulse; background is emitted when no opaque pixel is found.

Parameters:
ADD_WIDTH, 16, sprite RAM address width (RAM depth 2**ADD_WIDTH)
PIXEL_WIDTH, 12, pixel colour width
NR_OF_BLOBS, 4, number of blob request channels (>=1)
NR_OF_LAYERS, 4, number of layers, power of two >=2; LAYER_W = $clog2(NR_OF_LAYERS)
TRANSPARENT, 0, colour value treated as transparent

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
background  in  PIXEL_WIDTH  colour used when no opaque layer pixel exists
pix_valid_in  in  1  pixel strobe; request/layer/address sampled when high and block idle
request  in  NR_OF_BLOBS  per-blob request
layer  in  LAYER_W x NR_OF_BLOBS  per-blob layer (higher = on top)
address  in  ADD_WIDTH x NR_OF_BLOBS  per-blob sprite RAM address
wr_add  in  ADD_WIDTH  RAM write address
wr_data  in  PIXEL_WIDTH  RAM write data
wr_req  in  1  RAM write enable
pixel_out  out  PIXEL_WIDTH  composited pixel
pixel_valid  out  1  one-cycle pulse: pixel_out updated
busy  out  1  high when state != IDLE
overrun  out  1  sticky: a strobe was dropped

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high. Reset values: state=IDLE, pixel_out=0, pixel_valid=0, overrun=0, pending mask=0. RAM contents are not reset.
- Reset mid-operation aborts the scan immediately. No pixel_valid is produced for the aborted pixel.
- Capture (IDLE with pix_valid_in=1):
  - For each layer L, pending[L] = OR of request[i] where layer[i]==L.
  - Per layer, latch address[i] of the lowest-index requesting blob; within a layer, the lowest blob index wins.
- States: IDLE, ISSUE, CHECK, OUT.
- IDLE:
  - On capture, go to ISSUE if pending != 0, else to OUT with result=background.
  - pix_valid_in=0: stay in IDLE.
- ISSUE: drive RAM read address of the highest pending layer, clear its pending bit, go to CHECK.
- CHECK: RAM data is valid.
  - If data != key: result=data, go to OUT (remaining pending layers discarded).
  - Else if pending != 0: go to ISSUE.
  - Else: result=background, go to OUT.
- OUT: register pixel_out<=result, pixel_valid<=1 for the next cycle, go to IDLE.
- Latency: with strobe sampled at edge 0, pixel_valid is high for exactly one cycle after edge 1+2R. R = number of layers read (0..NR_OF_LAYERS).
- background is sampled at the point it is selected (capture or final CHECK).
- Strobe handling:
  - pix_valid_in while busy=1: strobe dropped, overrun<=1 (sticky until reset), no other effect.
  - A strobe coinciding with the pixel_valid cycle is accepted, because the state is then IDLE.
- RAM:
  - Simple dual-port, shared clk, synchronous read, latency 1.
  - Write port is independent of the FSM.
  - Read and write to the same address in the same cycle returns the old data (read-first).
- Transparency key ("key"): TRANSPARENT, or the port value if the macro below is defined.

Optional Feature:
COMPOSITOR_COLORKEY_EN
- Defined: adds input port transparent_key (PIXEL_WIDTH). The key is registered at capture and held for the whole scan; mid-scan changes do not affect the current pixel.
- Undefined: no such port; key is the constant TRANSPARENT.

Test Plan:
- No requests, pix_valid_in pulse, background=12'hABC -> pixel_valid one cycle after edge 1, pixel_out=12'hABC.
- RAM[0x10]=12'h0F0. Blob0 on layer 3 at 0x10, blob1 on layer 1 at 0x20 (RAM[0x20]=12'hF00) -> pixel_out=12'h0F0 after edge 3 (R=1); layer 1 never read.
- RAM[0x10]=0 (transparent) on layer 3, RAM[0x20]=12'hF00 on layer 1 -> pixel_out=12'hF00 after edge 5 (R=2).
- All requested layers transparent, background=12'h123 -> pixel_out=12'h123. Two blobs on the same layer (blob0 at 0x30=12'h00F, blob2 at 0x40=12'hFFF) -> 12'h00F wins.
- Second strobe two cycles after the first (busy) -> dropped, overrun=1, only one pixel_valid. Assert reset during CHECK -> no pixel_valid, outputs at reset values, next strobe served normally.
- With COMPOSITOR_COLORKEY_EN, transparent_key=12'hF0F: RAM[0x10]=12'hF0F on layer 3, RAM[0x20]=12'h000 on layer 2 -> pixel_out=12'h000.

Source files
------------

// File: rtl/layer_compositor.sv
// layer_compositor: per-pixel sprite compositor for the VGA path.
// Captures blob requests on a pixel strobe, reads the requested layers
// from an internal 1-cycle-latency sprite RAM from the top layer down,
// and emits the first opaque pixel (or background) with a valid pulse.
// Optional macro COMPOSITOR_COLORKEY_EN adds a run-time transparent_key
// input, captured with each pixel strobe and held for that scan.
module layer_compositor #(
    parameter int ADD_WIDTH    = 16,
    parameter int PIXEL_WIDTH  = 12,
    parameter int NR_OF_BLOBS  = 4,
    parameter int NR_OF_LAYERS = 4,
    parameter int TRANSPARENT  = 0,
    localparam int LAYER_W     = $clog2(NR_OF_LAYERS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [PIXEL_WIDTH-1:0]         background,
    input  logic                           pix_valid_in,
    input  logic [NR_OF_BLOBS-1:0]         request,
    input  logic [LAYER_W*NR_OF_BLOBS-1:0] layer,
    input  logic [ADD_WIDTH*NR_OF_BLOBS-1:0] address,
    input  logic [ADD_WIDTH-1:0]           wr_add,
    input  logic [PIXEL_WIDTH-1:0]         wr_data,
    input  logic                           wr_req,
`ifdef COMPOSITOR_COLORKEY_EN
    input  logic [PIXEL_WIDTH-1:0]         transparent_key,
`endif
    output logic [PIXEL_WIDTH-1:0]         pixel_out,
    output logic                           pixel_valid,
    output logic                           busy,
    output logic                           overrun
);

    typedef enum logic [1:0] {IDLE, ISSUE, CHECK, OUT} state_t;

    state_t                 state, next_state;
    logic [NR_OF_LAYERS-1:0] pending;
    logic [NR_OF_LAYERS-1:0] cap_pending;
    logic [ADD_WIDTH-1:0]   cap_addr [NR_OF_LAYERS];
    logic [ADD_WIDTH-1:0]   addr_q   [NR_OF_LAYERS];
    logic [LAYER_W-1:0]     top_layer;
    logic [ADD_WIDTH-1:0]   rd_addr;
    logic [PIXEL_WIDTH-1:0] rd_data_p1;
    logic [PIXEL_WIDTH-1:0] result;
    logic [PIXEL_WIDTH-1:0] key;
    logic [PIXEL_WIDTH-1:0] mem [2**ADD_WIDTH];
    logic                   capture;
    logic                   opaque;

    assign busy    = (state != IDLE);
    assign capture = (state == IDLE) && pix_valid_in;
    assign opaque  = (rd_data_p1 != key);

`ifdef COMPOSITOR_COLORKEY_EN
    logic [PIXEL_WIDTH-1:0] key_q;

    // Colour key is frozen at capture so mid-scan changes cannot affect this pixel
    always_ff @(posedge clk) begin
        if (capture)
            key_q <= transparent_key;
    end

    assign key = key_q;
`else
    assign key = PIXEL_WIDTH'(TRANSPARENT);
`endif

    // Fold blob requests into per-layer pending bits; scanning high to low makes the lowest blob index win
    always_comb begin
        cap_pending = '0;
        for (int l = 0; l < NR_OF_LAYERS; l++)
            cap_addr[l] = '0;
        for (int i = NR_OF_BLOBS - 1; i >= 0; i--) begin
            if (request[i]) begin
                cap_pending[layer[i*LAYER_W +: LAYER_W]] = 1'b1;
                cap_addr[layer[i*LAYER_W +: LAYER_W]]    = address[i*ADD_WIDTH +: ADD_WIDTH];
            end
        end
    end

    // Highest pending layer selects the RAM read address
    always_comb begin
        top_layer = '0;
        for (int l = 0; l < NR_OF_LAYERS; l++)
            if (pending[l])
                top_layer = LAYER_W'(l);
        rd_addr = addr_q[top_layer];
    end

    // Sprite RAM: independent write port, registered read-first read port
    always_ff @(posedge clk) begin
        if (wr_req)
            mem[wr_add] <= wr_data;
        rd_data_p1 <= mem[rd_addr];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pix_valid_in) next_state = (cap_pending != '0) ? ISSUE : OUT;
            ISSUE:   next_state = CHECK;
            CHECK:   if (opaque)              next_state = OUT;
                     else if (pending != '0)  next_state = ISSUE;
                     else                     next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control and output registers: pending mask, pixel output, valid pulse, sticky overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= '0;
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            if (busy && pix_valid_in)
                overrun <= 1'b1;
            case (state)
                IDLE:    if (pix_valid_in) pending <= cap_pending;
                ISSUE:   pending[top_layer] <= 1'b0;
                OUT: begin
                    pixel_out   <= result;
                    pixel_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers: captured addresses and the selected colour (background sampled when chosen)
    always_ff @(posedge clk) begin
        if (capture) begin
            addr_q <= cap_addr;
            if (cap_pending == '0)
                result <= background;
        end
        if (state == CHECK) begin
            if (opaque)
                result <= rd_data_p1;
            else if (pending == '0)
                result <= background;
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: directed testbench for layer_compositor.
module tb_layer_compositor;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] background;
    logic        pix_valid_in;
    logic [3:0]  request;
    logic [7:0]  layer;
    logic [63:0] address;
    logic [15:0] wr_add;
    logic [11:0] wr_data;
    logic        wr_req;
`ifdef COMPOSITOR_COLORKEY_EN
    logic [11:0] transparent_key;
`endif
    logic [11:0] pixel_out;
    logic        pixel_valid;
    logic        busy;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    layer_compositor dut (
        .clk            (clk),
        .reset          (reset),
        .background     (background),
        .pix_valid_in   (pix_valid_in),
        .request        (request),
        .layer          (layer),
        .address        (address),
        .wr_add         (wr_add),
        .wr_data        (wr_data),
        .wr_req         (wr_req),
`ifdef COMPOSITOR_COLORKEY_EN
        .transparent_key(transparent_key),
`endif
        .pixel_out      (pixel_out),
        .pixel_valid    (pixel_valid),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic ram_write(input logic [15:0] a, input logic [11:0] d);
        wr_add = a; wr_data = d; wr_req = 1'b1;
        @(posedge clk); #1;
        wr_req = 1'b0;
    endtask

    // Counts edges from now until pixel_valid; checks latency, pixel and single-cycle pulse
    task automatic wait_pixel(input string tag, input int exp_lat, input logic [11:0] exp_pix);
        int seen;
        logic [11:0] pix;
        seen = -1;
        pix  = '0;
        for (int n = 1; n <= 20 && seen < 0; n++) begin
            @(posedge clk); #1;
            if (pixel_valid) begin
                seen = n;
                pix  = pixel_out;
            end
        end
        check({tag, "_lat"}, seen, exp_lat);
        check({tag, "_pix"}, {20'd0, pix}, {20'd0, exp_pix});
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'd0, pixel_valid}, 32'd0);
    endtask

    task automatic run_pixel(input string tag, input logic [3:0] req, input logic [7:0] lay,
                             input logic [63:0] adr, input logic [11:0] bg,
                             input int exp_lat, input logic [11:0] exp_pix);
        request = req; layer = lay; address = adr; background = bg; pix_valid_in = 1'b1;
        @(posedge clk); #1;
        pix_valid_in = 1'b0;
        wait_pixel(tag, exp_lat, exp_pix);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; pix_valid_in = 1'b0; request = '0; layer = '0; address = '0;
        background = '0; wr_add = '0; wr_data = '0; wr_req = 1'b0;
`ifdef COMPOSITOR_COLORKEY_EN
        transparent_key = 12'h000;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_pixel_out", {20'd0, pixel_out}, 32'd0);
        check("rst_pixel_valid", {31'd0, pixel_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);

        ram_write(16'h0010, 12'h0F0);
        ram_write(16'h0020, 12'hF00);
        ram_write(16'h0030, 12'h00F);
        ram_write(16'h0040, 12'hFFF);
        ram_write(16'h0050, 12'h000);
        ram_write(16'h0060, 12'h000);
        ram_write(16'h0080, 12'h0AA);

        // No requests: background after one edge
        run_pixel("bg_only", 4'b0000, 8'h00, 64'h0, 12'hABC, 1, 12'hABC);
        // blob0 L3 @0x10 opaque, blob1 L1 @0x20: one read
        run_pixel("top_opaque", 4'b0011, 8'b00_00_01_11, {16'h0, 16'h0, 16'h0020, 16'h0010}, 12'hABC, 3, 12'h0F0);
        // top layer transparent, falls through to layer 1
        run_pixel("fall_through", 4'b0011, 8'b00_00_01_11, {16'h0, 16'h0, 16'h0020, 16'h0050}, 12'hABC, 5, 12'hF00);
        // all transparent -> background
        run_pixel("all_transp", 4'b0011, 8'b00_00_01_11, {16'h0, 16'h0, 16'h0060, 16'h0050}, 12'h123, 5, 12'h123);
        // blob0 and blob2 on layer 2: blob0 wins
        run_pixel("same_layer_a", 4'b0101, 8'b00_10_00_10, {16'h0, 16'h0040, 16'h0, 16'h0030}, 12'h123, 3, 12'h00F);
        // blob1 and blob3 on layer 2: blob1 wins
        run_pixel("same_layer_b", 4'b1010, 8'b10_00_10_00, {16'h0030, 16'h0, 16'h0040, 16'h0}, 12'h123, 3, 12'hFFF);
        // requests on layer 0 only (lowest layer still read)
        run_pixel("layer0", 4'b0100, 8'b00_00_00_00, {16'h0, 16'h0020, 16'h0, 16'h0}, 12'h123, 3, 12'hF00);

        // Strobe during the pixel_valid cycle is accepted
        request = '0; background = 12'hABC; pix_valid_in = 1'b1;
        @(posedge clk); #1;
        pix_valid_in = 1'b0;
        @(posedge clk); #1;
        check("b2b_first_valid", {31'd0, pixel_valid}, 32'd1);
        check("b2b_first_pix", {20'd0, pixel_out}, 32'hABC);
        background = 12'h321; pix_valid_in = 1'b1;
        @(posedge clk); #1;
        pix_valid_in = 1'b0;
        wait_pixel("b2b_second", 1, 12'h321);
        check("b2b_no_overrun", {31'd0, overrun}, 32'd0);

        // Read-first: write 0x80 in the same cycle it is read
        request = 4'b0001; layer = 8'b00_00_00_11; address = {48'h0, 16'h0080}; pix_valid_in = 1'b1;
        @(posedge clk); #1;
        pix_valid_in = 1'b0;
        wr_add = 16'h0080; wr_data = 12'h0BB; wr_req = 1'b1;
        @(posedge clk); #1;
        wr_req = 1'b0;
        wait_pixel("read_first_old", 2, 12'h0AA);
        run_pixel("read_first_new", 4'b0001, 8'b00_00_00_11, {48'h0, 16'h0080}, 12'h123, 3, 12'h0BB);

        // Strobe while busy is dropped and sets overrun
        request = 4'b0011; layer = 8'b00_00_01_11; address = {16'h0, 16'h0, 16'h0020, 16'h0010};
        pix_valid_in = 1'b1;
        @(posedge clk); #1;
        pix_valid_in = 1'b0;
        @(posedge clk); #1;
        pix_valid_in = 1'b1;
        @(posedge clk); #1;
        pix_valid_in = 1'b0;
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (pixel_valid) pulses++;
        end
        check("ovr_pulses", pulses, 32'd1);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        run_pixel("ovr_after", 4'b0011, 8'b00_00_01_11, {16'h0, 16'h0, 16'h0020, 16'h0010}, 12'h123, 3, 12'h0F0);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Reset during CHECK aborts the pixel
        pix_valid_in = 1'b1;
        @(posedge clk); #1;
        pix_valid_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_valid", {31'd0, pixel_valid}, 32'd0);
        check("abort_pixel_out", {20'd0, pixel_out}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_overrun", {31'd0, overrun}, 32'd0);
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (pixel_valid) pulses++;
        end
        check("abort_no_pulse", pulses, 32'd0);
        run_pixel("post_abort", 4'b0011, 8'b00_00_01_11, {16'h0, 16'h0, 16'h0020, 16'h0010}, 12'h123, 3, 12'h0F0);

`ifdef COMPOSITOR_COLORKEY_EN
        ram_write(16'h0070, 12'hF0F);
        transparent_key = 12'hF0F;
        run_pixel("colorkey", 4'b0011, 8'b00_00_10_11, {16'h0, 16'h0, 16'h0050, 16'h0070}, 12'h123, 5, 12'h000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
